// File: rtl/hpdcache_cmo_req_adapter.sv
// rtl/hpdcache_cmo_req_adapter.sv - CMO request buffer, one-hot translation and response return
//
// Buffers encoded CMO requests in a small FIFO and issues them one at a time to the
// CMO handler. It detects completion and returns sid/tid/error to the requester.
// Optional feature macro: HPDCACHE_CMO_PERF_EN (perf counters; tied to 0 when undefined).
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   core_req_*                      encoded CMO request in (valid/ready, op, addr, wdata, sid, tid, need_rsp)
//   cmoh_req_*                      one-hot request to the CMO handler (valid/ready, op, addr, wdata)
//   core_rsp_*                      response to requester (valid/ready, sid, tid, error)
//   perf_cmo_done_o, perf_stall_o   completed CMO count, head-waiting-for-handler cycles
module hpdcache_cmo_req_adapter #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_WIDTH = 49,
  parameter int WORD_WIDTH = 64,
  parameter int SID_WIDTH  = 3,
  parameter int TID_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_valid_i,
  output logic                  core_req_ready_o,
  input  logic [2:0]            core_req_op_i,
  input  logic [ADDR_WIDTH-1:0] core_req_addr_i,
  input  logic [WORD_WIDTH-1:0] core_req_wdata_i,
  input  logic [SID_WIDTH-1:0]  core_req_sid_i,
  input  logic [TID_WIDTH-1:0]  core_req_tid_i,
  input  logic                  core_req_need_rsp_i,
  output logic                  cmoh_req_valid_o,
  input  logic                  cmoh_req_ready_i,
  output logic [3:0]            cmoh_req_op_o,
  output logic [ADDR_WIDTH-1:0] cmoh_req_addr_o,
  output logic [WORD_WIDTH-1:0] cmoh_req_wdata_o,
  output logic                  core_rsp_valid_o,
  input  logic                  core_rsp_ready_i,
  output logic [SID_WIDTH-1:0]  core_rsp_sid_o,
  output logic [TID_WIDTH-1:0]  core_rsp_tid_o,
  output logic                  core_rsp_error_o,
  output logic [31:0]           perf_cmo_done_o,
  output logic [31:0]           perf_stall_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 3 + ADDR_WIDTH + WORD_WIDTH + SID_WIDTH + TID_WIDTH + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] INFLIGHT = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  logic [2:0]            head_op;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WORD_WIDTH-1:0] head_wdata;
  logic [SID_WIDTH-1:0]  head_sid;
  logic [TID_WIDTH-1:0]  head_tid;
  logic                  head_need;
  logic                  head_legal;

  logic [1:0] state, state_d;
  logic       rsp_load, rsp_err_d;
  logic [SID_WIDTH-1:0] rsp_sid;
  logic [TID_WIDTH-1:0] rsp_tid;
  logic       rsp_err, rsp_need;

  // Ready comes only from the registered count, so a full FIFO never accepts even
  // when the head pops in the same cycle.
  assign full             = (count == CNT_W'(FIFO_DEPTH));
  assign empty            = (count == '0);
  assign core_req_ready_o = ~full;
  assign push             = core_req_valid_i & ~full;

  assign {head_op, head_addr, head_wdata, head_sid, head_tid, head_need} = mem[rd_ptr];
  assign head_legal = ~head_op[2];

  // Payload storage carries no reset; visibility is gated by count and state.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {core_req_op_i, core_req_addr_i, core_req_wdata_i,
                      core_req_sid_i, core_req_tid_i, core_req_need_rsp_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    rsp_load  = 1'b0;
    rsp_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_legal) begin
            state_d = ISSUE;
          end else begin
            // Illegal ops are consumed here and never reach the handler.
            pop = 1'b1;
            if (head_need) begin
              state_d   = RESP;
              rsp_load  = 1'b1;
              rsp_err_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (cmoh_req_ready_i) begin
          pop      = 1'b1;
          rsp_load = 1'b1;
          state_d  = INFLIGHT;
        end
      end
      INFLIGHT: begin
        // Handler ready again (earliest the cycle after the handshake) means done.
        if (cmoh_req_ready_i) state_d = rsp_need ? RESP : IDLE;
      end
      RESP: begin
        if (core_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rsp_sid  <= '0;
      rsp_tid  <= '0;
      rsp_err  <= 1'b0;
      rsp_need <= 1'b0;
    end else begin
      state <= state_d;
      if (rsp_load) begin
        rsp_sid  <= head_sid;
        rsp_tid  <= head_tid;
        rsp_err  <= rsp_err_d;
        rsp_need <= head_need;
      end
    end
  end

  assign cmoh_req_valid_o = (state == ISSUE);
  assign cmoh_req_op_o    = cmoh_req_valid_o ? (4'b0001 << head_op[1:0]) : 4'b0000;
  assign cmoh_req_addr_o  = cmoh_req_valid_o ? head_addr  : '0;
  assign cmoh_req_wdata_o = cmoh_req_valid_o ? head_wdata : '0;

  assign core_rsp_valid_o = (state == RESP);
  assign core_rsp_sid_o   = rsp_sid;
  assign core_rsp_tid_o   = rsp_tid;
  assign core_rsp_error_o = rsp_err;

`ifdef HPDCACHE_CMO_PERF_EN
  logic        done_evt;
  logic [31:0] perf_done, perf_stall;

  // Legal CMOs complete in INFLIGHT; illegal ones complete when popped.
  assign done_evt = ((state == IDLE) && !empty && !head_legal) ||
                    ((state == INFLIGHT) && cmoh_req_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_done  <= '0;
      perf_stall <= '0;
    end else begin
      if (done_evt && (perf_done != '1)) perf_done <= perf_done + 32'd1;
      if ((state == ISSUE) && !cmoh_req_ready_i && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end

  assign perf_cmo_done_o = perf_done;
  assign perf_stall_o    = perf_stall;
`else
  assign perf_cmo_done_o = '0;
  assign perf_stall_o    = '0;
`endif

endmodule

// File: tb/tb_hpdcache_cmo_req_adapter.sv
// tb/tb_hpdcache_cmo_req_adapter.sv - self-checking bench for hpdcache_cmo_req_adapter
module tb_hpdcache_cmo_req_adapter;

  localparam int AW = 49;
  localparam int WW = 64;
  localparam int SW = 3;
  localparam int TW = 6;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          core_req_valid_i;
  logic          core_req_ready_o;
  logic [2:0]    core_req_op_i;
  logic [AW-1:0] core_req_addr_i;
  logic [WW-1:0] core_req_wdata_i;
  logic [SW-1:0] core_req_sid_i;
  logic [TW-1:0] core_req_tid_i;
  logic          core_req_need_rsp_i;
  logic          cmoh_req_valid_o;
  logic          cmoh_req_ready_i;
  logic [3:0]    cmoh_req_op_o;
  logic [AW-1:0] cmoh_req_addr_o;
  logic [WW-1:0] cmoh_req_wdata_o;
  logic          core_rsp_valid_o;
  logic          core_rsp_ready_i;
  logic [SW-1:0] core_rsp_sid_o;
  logic [TW-1:0] core_rsp_tid_o;
  logic          core_rsp_error_o;
  logic [31:0]   perf_cmo_done_o;
  logic [31:0]   perf_stall_o;

  hpdcache_cmo_req_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
    .core_req_wdata_i(core_req_wdata_i), .core_req_sid_i(core_req_sid_i),
    .core_req_tid_i(core_req_tid_i), .core_req_need_rsp_i(core_req_need_rsp_i),
    .cmoh_req_valid_o(cmoh_req_valid_o), .cmoh_req_ready_i(cmoh_req_ready_i),
    .cmoh_req_op_o(cmoh_req_op_o), .cmoh_req_addr_o(cmoh_req_addr_o),
    .cmoh_req_wdata_o(cmoh_req_wdata_o),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
    .core_rsp_sid_o(core_rsp_sid_o), .core_rsp_tid_o(core_rsp_tid_o),
    .core_rsp_error_o(core_rsp_error_o),
    .perf_cmo_done_o(perf_cmo_done_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int cycle = 0;
  always @(posedge clk_i) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Transaction-level model: every accepted request yields, in order, one expected
  // handler issue (legal ops) and one expected response (when a response is asked for).
  typedef struct { logic [3:0] op; logic [AW-1:0] addr; logic [WW-1:0] wdata; } iss_t;
  typedef struct { logic [SW-1:0] sid; logic [TW-1:0] tid; logic err; } rsp_t;
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   rsp_log[$];
  int   n_issue = 0;
  int   n_rsp = 0;
  int   n_accept = 0;
  int   exp_stall = 0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_iss.delete();
      exp_rsp.delete();
      n_accept  = 0;
      exp_stall = 0;
    end else begin
`ifdef HPDCACHE_CMO_PERF_EN
      chk("perf_stall", perf_stall_o, exp_stall);
`else
      chk("perf_stall_tied", perf_stall_o, 0);
`endif
      if (core_req_valid_i && core_req_ready_o) begin
        n_accept++;
        if (core_req_op_i < 3'd4) begin
          iss_t e;
          e.op    = 4'b0001 << core_req_op_i;
          e.addr  = core_req_addr_i;
          e.wdata = core_req_wdata_i;
          exp_iss.push_back(e);
        end
        if (core_req_need_rsp_i) begin
          rsp_t r;
          r.sid = core_req_sid_i;
          r.tid = core_req_tid_i;
          r.err = (core_req_op_i >= 3'd4);
          exp_rsp.push_back(r);
        end
      end
      chk("one_cmo_at_a_time", {63'd0, cmoh_req_valid_o && core_rsp_valid_o}, 0);
      if (cmoh_req_valid_o) begin
        tests++;
        if (exp_iss.size() == 0) begin
          fails++;
          $display("FAIL cmoh_unexpected: got op 0x%0h expected no request (cycle %0d)", cmoh_req_op_o, cycle);
        end else begin
          chk("cmoh_op", cmoh_req_op_o, exp_iss[0].op);
          chk("cmoh_addr", cmoh_req_addr_o, exp_iss[0].addr);
          chk("cmoh_wdata", cmoh_req_wdata_o, exp_iss[0].wdata);
          if (cmoh_req_ready_i) begin
            void'(exp_iss.pop_front());
            n_issue++;
          end
        end
        if (!cmoh_req_ready_i) exp_stall++;
      end
      if (core_rsp_valid_o) begin
        tests++;
        if (exp_rsp.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got tid %0d expected no response (cycle %0d)", core_rsp_tid_o, cycle);
        end else begin
          chk("rsp_sid", core_rsp_sid_o, exp_rsp[0].sid);
          chk("rsp_tid", core_rsp_tid_o, exp_rsp[0].tid);
          chk("rsp_err", core_rsp_error_o, exp_rsp[0].err);
          if (core_rsp_ready_i) begin
            void'(exp_rsp.pop_front());
            rsp_log.push_back(int'(core_rsp_tid_o));
            n_rsp++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                      input logic [SW-1:0] sid, input logic [TW-1:0] tid, input logic need,
                      output int waits);
    bit done = 0;
    core_req_valid_i = 1'b1;
    core_req_op_i = op; core_req_addr_i = addr; core_req_wdata_i = wd;
    core_req_sid_i = sid; core_req_tid_i = tid; core_req_need_rsp_i = need;
    waits = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (core_req_ready_o) done = 1;
      else waits++;
      step();
    end
    core_req_valid_i = 1'b0;
    if (!done) chk("push_timeout", 1, 0);
  endtask

  task automatic wait_issue(output int cyc, output logic [3:0] op, output logic [WW-1:0] wd);
    bit done = 0;
    cyc = -1; op = '0; wd = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (cmoh_req_valid_o && cmoh_req_ready_i) begin
        done = 1; cyc = cycle; op = cmoh_req_op_o; wd = cmoh_req_wdata_o;
      end
      step();
    end
    if (!done) chk("issue_timeout", 1, 0);
  endtask

  task automatic wait_rsp(output int cyc, output logic [SW-1:0] sid, output logic [TW-1:0] tid,
                          output logic err);
    bit done = 0;
    cyc = -1; sid = '0; tid = '0; err = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (core_rsp_valid_o) begin
        done = 1; cyc = cycle; sid = core_rsp_sid_o; tid = core_rsp_tid_o; err = core_rsp_error_o;
      end
      step();
    end
    if (!done) chk("rsp_timeout", 1, 0);
  endtask

  task automatic wait_quiet();
    bit q = 0;
    for (int i = 0; i < 500 && !q; i++) begin
      step();
      q = (exp_iss.size() == 0) && (exp_rsp.size() == 0) && !core_rsp_valid_o && !cmoh_req_valid_o;
    end
    if (!q) chk("quiet_timeout", 1, 0);
    repeat (3) step();
`ifdef HPDCACHE_CMO_PERF_EN
    chk("perf_cmo_done", perf_cmo_done_o, n_accept);
`else
    chk("perf_cmo_done_tied", perf_cmo_done_o, 0);
`endif
  endtask

  int w, ci, cr, rc, s0, n0, r0;
  logic [3:0]    op_s;
  logic [WW-1:0] wd_s;
  logic [SW-1:0] sid_s;
  logic [TW-1:0] tid_s;
  logic          err_s;

  initial begin
    rst_ni = 1'b0;
    core_req_valid_i = 0; core_req_op_i = 0; core_req_addr_i = 0; core_req_wdata_i = 0;
    core_req_sid_i = 0; core_req_tid_i = 0; core_req_need_rsp_i = 0;
    cmoh_req_ready_i = 1; core_rsp_ready_i = 1;
    repeat (3) step();
    chk("reset_req_ready", core_req_ready_o, 1);
    chk("reset_cmoh_valid", cmoh_req_valid_o, 0);
    chk("reset_rsp_valid", core_rsp_valid_o, 0);
    chk("reset_rsp_fields", {core_rsp_sid_o, core_rsp_tid_o, core_rsp_error_o}, 0);
    chk("reset_perf", {perf_cmo_done_o, perf_stall_o}, 0);
    rst_ni = 1'b1;
    step();

    // FENCE with an always-ready handler: response two cycles after the issue handshake.
    push(3'd0, 49'h1000, 64'h0, 3'd1, 6'd5, 1'b1, w);
    wait_issue(ci, op_s, wd_s);
    chk("fence_op", op_s, 4'b0001);
    wait_rsp(cr, sid_s, tid_s, err_s);
    chk("fence_rsp_latency", cr - ci, 2);
    chk("fence_rsp_sid", sid_s, 1);
    chk("fence_rsp_tid", tid_s, 5);
    chk("fence_rsp_err", err_s, 0);
    wait_quiet();

    // INVAL_SET with the handler busy 20 cycles after issue.
    push(3'd2, 49'h2_0040, 64'h0F, 3'd2, 6'd7, 1'b1, w);
    wait_issue(ci, op_s, wd_s);
    chk("set_op", op_s, 4'b0100);
    chk("set_wdata", wd_s, 64'h0F);
    cmoh_req_ready_i = 0;
    s0 = perf_stall_o;
    repeat (20) step();
    chk("set_no_early_rsp", core_rsp_valid_o, 0);
    cmoh_req_ready_i = 1;
    rc = cycle;
    wait_rsp(cr, sid_s, tid_s, err_s);
    chk("set_rsp_latency", cr - rc, 1);
    chk("set_rsp_tid", tid_s, 7);
    chk("set_stall_unchanged", perf_stall_o, s0);
    wait_quiet();

    // Illegal opcodes: error response, or silently dropped without need_rsp.
    n0 = n_issue;
    push(3'd5, 49'h3000, 64'h0, 3'd3, 6'd9, 1'b1, w);
    wait_rsp(cr, sid_s, tid_s, err_s);
    chk("illegal_err", err_s, 1);
    chk("illegal_tid", tid_s, 9);
    wait_quiet();
    r0 = n_rsp;
    push(3'd6, 49'h3100, 64'h0, 3'd4, 6'd10, 1'b0, w);
    repeat (10) step();
    chk("illegal_drop_no_rsp", n_rsp, r0);
    chk("illegal_not_forwarded", n_issue, n0);
    wait_quiet();

    // Three back-to-back requests against a busy handler with a 2-entry FIFO.
    cmoh_req_ready_i = 0;
    push(3'd1, 49'h4000, 64'h1, 3'd5, 6'd10, 1'b1, w);
    push(3'd2, 49'h4100, 64'h3, 3'd5, 6'd11, 1'b1, w);
    chk("fifo_full_ready", core_req_ready_o, 0);
    fork
      push(3'd3, 49'h4200, 64'h7, 3'd5, 6'd12, 1'b1, w);
      begin repeat (5) step(); cmoh_req_ready_i = 1; end
    join
    chk("third_stalled", {63'd0, w >= 5}, 1);
    wait_quiet();
    chk("order_tid0", rsp_log[rsp_log.size()-3], 10);
    chk("order_tid1", rsp_log[rsp_log.size()-2], 11);
    chk("order_tid2", rsp_log[rsp_log.size()-1], 12);

    // Response back-pressure: fields stable and the next request held back.
    core_rsp_ready_i = 0;
    push(3'd0, 49'h5000, 64'h0, 3'd6, 6'd20, 1'b1, w);
    push(3'd1, 49'h5100, 64'h0, 3'd6, 6'd21, 1'b1, w);
    wait_rsp(cr, sid_s, tid_s, err_s);
    repeat (10) step();
    chk("bp_rsp_valid", core_rsp_valid_o, 1);
    chk("bp_rsp_tid", core_rsp_tid_o, 20);
    chk("bp_rsp_sid", core_rsp_sid_o, 6);
    chk("bp_next_held", cmoh_req_valid_o, 0);
    core_rsp_ready_i = 1;
    wait_quiet();
    chk("bp_order0", rsp_log[rsp_log.size()-2], 20);
    chk("bp_order1", rsp_log[rsp_log.size()-1], 21);

    // Reset while a CMO is in flight with another queued.
    push(3'd3, 49'h6000, 64'hFF, 3'd7, 6'd30, 1'b1, w);
    wait_issue(ci, op_s, wd_s);
    cmoh_req_ready_i = 0;
    step();
    push(3'd0, 49'h6100, 64'h0, 3'd7, 6'd31, 1'b1, w);
    rst_ni = 1'b0;
    step();
    chk("rst_req_ready", core_req_ready_o, 1);
    chk("rst_cmoh_valid", cmoh_req_valid_o, 0);
    chk("rst_cmoh_payload", {cmoh_req_op_o, cmoh_req_wdata_o}, 0);
    chk("rst_cmoh_addr", cmoh_req_addr_o, 0);
    chk("rst_rsp_valid", core_rsp_valid_o, 0);
    chk("rst_rsp_fields", {core_rsp_sid_o, core_rsp_tid_o, core_rsp_error_o}, 0);
    chk("rst_perf", {perf_cmo_done_o, perf_stall_o}, 0);
    rst_ni = 1'b1;
    cmoh_req_ready_i = 1;
    n0 = n_issue;
    r0 = n_rsp;
    repeat (6) step();
    chk("rst_fifo_empty", n_issue, n0);
    chk("rst_no_rsp", n_rsp, r0);
    wait_quiet();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
